// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared widths and select type for the 1-to-8 demux
package demux_pkg;

  localparam int DEMUX_SEL_W = 3;
  localparam int DEMUX_N_OUT = 8;

  typedef logic [DEMUX_SEL_W-1:0] demux_sel_t;

endpackage

// File: rtl/demux_1x2.sv
// rtl/demux_1x2.sv - combinational 1-to-2 demux stage used as a tree node
module demux_1x2 (
  input  logic d,
  input  logic s,
  output logic a,
  output logic b
);

  assign a = d & ~s;
  assign b = d & s;

endmodule

// File: rtl/demux_1x8_using_1x2.sv
// rtl/demux_1x8_using_1x2.sv - registered 1-to-8 demux built from a tree of seven 1-to-2 stages
// Optional input register stage enabled by DEMUX_1X8_INPUT_REG_EN (adds one clock of latency).
module demux_1x8_using_1x2
  import demux_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       I,
  input  demux_sel_t sel,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3,
  output logic       y4,
  output logic       y5,
  output logic       y6,
  output logic       y7
);

  logic                   data_in;
  demux_sel_t             sel_in;
  logic                   half_lo, half_hi;
  logic [3:0]             quarter;
  logic [DEMUX_N_OUT-1:0] y_next;
  logic [DEMUX_N_OUT-1:0] y_q;

`ifdef DEMUX_1X8_INPUT_REG_EN
  logic       data_q;
  demux_sel_t sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= 1'b0;
      sel_q  <= '0;
    end else begin
      data_q <= I;
      sel_q  <= sel;
    end
  end

  assign data_in = data_q;
  assign sel_in  = sel_q;
`else
  assign data_in = I;
  assign sel_in  = sel;
`endif

  // Level 1 picks the half on sel[2], level 2 the quarter on sel[1], level 3 the leaf on sel[0].
  demux_1x2 u_l1   (.d(data_in),    .s(sel_in[2]), .a(half_lo),    .b(half_hi));

  demux_1x2 u_l2_0 (.d(half_lo),    .s(sel_in[1]), .a(quarter[0]), .b(quarter[1]));
  demux_1x2 u_l2_1 (.d(half_hi),    .s(sel_in[1]), .a(quarter[2]), .b(quarter[3]));

  demux_1x2 u_l3_0 (.d(quarter[0]), .s(sel_in[0]), .a(y_next[0]),  .b(y_next[1]));
  demux_1x2 u_l3_1 (.d(quarter[1]), .s(sel_in[0]), .a(y_next[2]),  .b(y_next[3]));
  demux_1x2 u_l3_2 (.d(quarter[2]), .s(sel_in[0]), .a(y_next[4]),  .b(y_next[5]));
  demux_1x2 u_l3_3 (.d(quarter[3]), .s(sel_in[0]), .a(y_next[6]),  .b(y_next[7]));

  // All eight outputs update together, so a select hop never shows two highs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_next;
    end
  end

  assign y0 = y_q[0];
  assign y1 = y_q[1];
  assign y2 = y_q[2];
  assign y3 = y_q[3];
  assign y4 = y_q[4];
  assign y5 = y_q[5];
  assign y6 = y_q[6];
  assign y7 = y_q[7];

endmodule

// File: tb/tb_demux_1x8_using_1x2.sv
// tb/tb_demux_1x8_using_1x2.sv - directed self-checking bench for demux_1x8_using_1x2
`timescale 1ns/1ps
module tb_demux_1x8_using_1x2;

`ifdef DEMUX_1X8_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       I;
  logic [2:0] sel;
  logic       y0, y1, y2, y3, y4, y5, y6, y7;
  logic [7:0] y;

  int checks;
  int errors;

  logic [7:0] onehot_tbl [8];

  demux_1x8_using_1x2 dut (
    .clk(clk), .rst(rst), .I(I), .sel(sel),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .y4(y4), .y5(y5), .y6(y6), .y7(y7)
  );

  assign y = {y7, y6, y5, y4, y3, y2, y1, y0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; I = 1'b1; sel = 3'b101;
    #3;
    checks++;
    if (y !== 8'h00) begin
      errors++;
      $display("FAIL reset_immediate y=%b expected=%b", y, 8'h00);
    end
    tick(3);
    checks++;
    if (y !== 8'h00) begin
      errors++;
      $display("FAIL reset_held y=%b expected=%b", y, 8'h00);
    end
    rst = 1'b0;
    tick(LAT);
    checks++;
    if (y !== 8'h20) begin
      errors++;
      $display("FAIL reset_release y=%b expected=%b", y, 8'h20);
    end
  endtask

  task automatic test_sweep;
    for (int s = 0; s < 8; s++) begin
      I = 1'b1; sel = 3'(s);
      tick(LAT);
      checks++;
      if (y !== onehot_tbl[s]) begin
        errors++;
        $display("FAIL sweep sel=%0d y=%b expected=%b", s, y, onehot_tbl[s]);
      end
    end
  endtask

  task automatic test_zero_data;
    for (int s = 0; s < 8; s++) begin
      I = 1'b0; sel = 3'(s);
      tick(LAT);
      checks++;
      if (y !== 8'h00) begin
        errors++;
        $display("FAIL zero_data sel=%0d y=%b expected=%b", s, y, 8'h00);
      end
    end
  endtask

  task automatic test_select_hop;
    I = 1'b1; sel = 3'd2;
    tick(LAT);
    checks++;
    if (y !== 8'h04) begin
      errors++;
      $display("FAIL hop_first y=%b expected=%b", y, 8'h04);
    end
    sel = 3'd6;
    tick(LAT);
    checks++;
    if (y !== 8'h40) begin
      errors++;
      $display("FAIL hop_second y=%b expected=%b", y, 8'h40);
    end
  endtask

  task automatic test_midrun_reset;
    I = 1'b1; sel = 3'd7;
    tick(LAT);
    checks++;
    if (y !== 8'h80) begin
      errors++;
      $display("FAIL midrun_before y=%b expected=%b", y, 8'h80);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (y !== 8'h00) begin
      errors++;
      $display("FAIL midrun_async_clear y=%b expected=%b", y, 8'h00);
    end
    rst = 1'b0;
    tick(LAT);
    checks++;
    if (y !== 8'h80) begin
      errors++;
      $display("FAIL midrun_recover y=%b expected=%b", y, 8'h80);
    end
  endtask

  task automatic test_latency;
    I = 1'b0; sel = 3'd0;
    tick(LAT + 1);
    I = 1'b1; sel = 3'd4;
`ifdef DEMUX_1X8_INPUT_REG_EN
    tick(1);
    checks++;
    if (y !== 8'h00) begin
      errors++;
      $display("FAIL latency_edge_k y=%b expected=%b", y, 8'h00);
    end
    tick(1);
    checks++;
    if (y !== 8'h10) begin
      errors++;
      $display("FAIL latency_edge_k1 y=%b expected=%b", y, 8'h10);
    end
`else
    tick(1);
    checks++;
    if (y !== 8'h10) begin
      errors++;
      $display("FAIL latency_edge_k y=%b expected=%b", y, 8'h10);
    end
    I = 1'b0;
    tick(1);
    checks++;
    if (y !== 8'h00) begin
      errors++;
      $display("FAIL latency_drop y=%b expected=%b", y, 8'h00);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    onehot_tbl[0] = 8'h01; onehot_tbl[1] = 8'h02;
    onehot_tbl[2] = 8'h04; onehot_tbl[3] = 8'h08;
    onehot_tbl[4] = 8'h10; onehot_tbl[5] = 8'h20;
    onehot_tbl[6] = 8'h40; onehot_tbl[7] = 8'h80;
    rst = 1'b1; I = 1'b0; sel = 3'd0;

    test_reset();
    test_sweep();
    test_zero_data();
    test_select_hop();
    test_midrun_reset();
    test_latency();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
